// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, port count, direction codes and port bit order.
// Request vectors are ordered [L,W,E,S,N] as bits [4:0].
package noc_pkg;

    localparam int unsigned FLIT_W    = 64;
    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned PortN = 0;
    localparam int unsigned PortS = 1;
    localparam int unsigned PortE = 2;
    localparam int unsigned PortW = 3;
    localparam int unsigned PortL = 4;

    typedef enum logic [2:0] {
        DirN       = 3'b000,
        DirS       = 3'b001,
        DirE       = 3'b010,
        DirW       = 3'b011,
        DirL       = 3'b100,
        DirInvalid = 3'b111
    } dir_e;

    function automatic dir_e port_to_dir(input logic [2:0] port);
        dir_e dir;
        dir = DirInvalid;
        unique case (port)
            3'(PortN): dir = DirN;
            3'(PortS): dir = DirS;
            3'(PortE): dir = DirE;
            3'(PortW): dir = DirW;
            3'(PortL): dir = DirL;
            default:   dir = DirInvalid;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/output_module_if.sv
// Request/grant and outgoing link signals of one router output stage.
// slave is the output stage's view; master is the surrounding router's view.
interface output_module_if #(
    parameter int unsigned DATA_W = noc_pkg::FLIT_W,
    parameter int unsigned NUM_IN = noc_pkg::NUM_PORTS,
    parameter int unsigned DEPTH  = 4
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [NUM_IN-1:0]        req_valid;
    logic [NUM_IN*DATA_W-1:0] req_data;
    logic [NUM_IN-1:0]        grant;
    logic [2:0]               grant_dir;
    logic                     link_valid;
    logic [DATA_W-1:0]        link_data;
    logic                     recv_full;
    logic                     fifo_full;
    logic [CntW-1:0]          ocup;

    modport slave (
        input  req_valid, req_data, recv_full,
        output grant, grant_dir, link_valid, link_data, fifo_full, ocup
    );

    modport master (
        output req_valid, req_data, recv_full,
        input  grant, grant_dir, link_valid, link_data, fifo_full, ocup
    );

endinterface

// File: rtl/link_fifo.sv
// Small circular flit buffer; full/empty come from the occupancy count, not the pointers.
// Synchronous active-high reset clears pointers, count and storage.
module link_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/output_module.sv
// Router output stage: round-robin arbitration over the input ports feeding a link FIFO
// that drains under the neighbour's recv_full back-pressure.
module output_module
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = FLIT_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NUM_IN = NUM_PORTS
) (
    input  logic            clk,
    input  logic            reset,
    output_module_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(NUM_IN);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW:0]     scan_sum;
    logic [PtrW-1:0]   win_idx;
    logic              win_found;
    logic              grant_ok;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] head;
    logic [CntW-1:0]   count;
    logic              full, empty;
    logic              pop;

    // First requester found scanning ptr, ptr+1, ... modulo NUM_IN.
    always_comb begin
        scan_sum  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            scan_sum = {1'b0, ptr_q} + (PtrW+1)'(k);
            if (scan_sum >= (PtrW+1)'(NUM_IN)) scan_sum = scan_sum - (PtrW+1)'(NUM_IN);
            if (!win_found && bus.req_valid[scan_sum[PtrW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[PtrW-1:0];
            end
        end
    end

    // No grant when full, even on a pop cycle, so recv_full stays off the grant path.
    assign grant_ok  = win_found && !full && !reset;
    assign push_data = bus.req_data[win_idx*DATA_W +: DATA_W];

    always_comb begin
        ptr_d         = ptr_q;
        bus.grant     = '0;
        bus.grant_dir = DirInvalid;
        if (grant_ok) begin
            bus.grant     = NUM_IN'(1) << win_idx;
            bus.grant_dir = port_to_dir(3'(win_idx));
            ptr_d         = (win_idx == PtrW'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign pop = !empty && !bus.recv_full;

    link_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_link_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (grant_ok),
        .pop_i   (pop),
        .wdata_i (push_data),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.link_valid = !empty;
    assign bus.link_data  = head;
    assign bus.fifo_full  = full;
    assign bus.ocup       = count;

endmodule

// File: tb/tb_output_module.sv
// Directed bench for output_module: reset, fairness, back-pressure, full-with-pop,
// pointer wrap-around under random recv_full, and reset in mid-operation.
module tb_output_module;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    output_module_if #(.DATA_W(64), .NUM_IN(5), .DEPTH(4)) bus ();

    output_module #(
        .DATA_W (64),
        .DEPTH  (4),
        .NUM_IN (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int port, input logic [63:0] v);
        bus.req_data[port*64 +: 64] = v;
    endtask

    logic [63:0] exp_q [$];
    logic [4:0]  pend;
    int          sent;
    int          rcvd;
    int          cyc;

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.recv_full = 1'b0;

        // Reset: grant suppressed even with requests present
        tick();
        bus.req_valid = 5'b11111;
        #1;
        chk("rst_grant", 64'(bus.grant), 64'h0);
        chk("rst_dir", 64'(bus.grant_dir), 64'h7);
        tick();
        reset = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("rst_link_valid", 64'(bus.link_valid), 64'h0);
        chk("rst_ocup", 64'(bus.ocup), 64'h0);
        chk("rst_fifo_full", 64'(bus.fifo_full), 64'h0);
        chk("rst_link_data", bus.link_data, 64'h0);
        chk("rst_grant_idle", 64'(bus.grant), 64'h0);
        chk("rst_dir_idle", 64'(bus.grant_dir), 64'h7);

        // Single N request, visible on the link one cycle later
        set_data(0, 64'h1);
        bus.req_valid = 5'b00001;
        #1;
        chk("def_grant", 64'(bus.grant), 64'h1);
        chk("def_dir", 64'(bus.grant_dir), 64'h0);
        tick();
        bus.req_valid = '0;
        #1;
        chk("def_link_valid", 64'(bus.link_valid), 64'h1);
        chk("def_link_data", bus.link_data, 64'h1);
        chk("def_ocup", 64'(bus.ocup), 64'h1);
        tick();
        chk("def_drain", 64'(bus.ocup), 64'h0);

        // Fairness from a fresh pointer: N,S,E,W,L,N
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) set_data(i, 64'h100 + 64'(i));
        bus.req_valid = 5'b11111;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("fair_grant", 64'(bus.grant), 64'(1) << (k % 5));
            chk("fair_dir", 64'(bus.grant_dir), 64'(k % 5));
            if (k > 0) begin
                chk("fair_ocup", 64'(bus.ocup), 64'h1);
                chk("fair_link", bus.link_data, 64'h100 + 64'((k - 1) % 5));
            end
            tick();
        end
        bus.req_valid = '0;
        #1;
        chk("fair_last", bus.link_data, 64'h100);
        tick();
        chk("fair_drain", 64'(bus.ocup), 64'h0);

        // Back-pressure: pointer now at S, so S,E,W,L fill the FIFO and N waits
        bus.recv_full = 1'b1;
        for (int i = 0; i < 5; i++) set_data(i, 64'h200 + 64'(i));
        pend = 5'b11111;
        bus.req_valid = pend;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_grant", 64'(bus.grant), 64'(1) << (k + 1));
            tick();
            pend[k+1] = 1'b0;
            bus.req_valid = pend;
            #1;
        end
        chk("bp_ocup_full", 64'(bus.ocup), 64'h4);
        chk("bp_fifo_full", 64'(bus.fifo_full), 64'h1);
        chk("bp_wait_grant", 64'(bus.grant), 64'h0);
        chk("bp_head", bus.link_data, 64'h201);
        tick();
        chk("bp_hold_ocup", 64'(bus.ocup), 64'h4);
        chk("bp_hold_head", bus.link_data, 64'h201);
        chk("bp_hold_valid", 64'(bus.link_valid), 64'h1);

        // Full with pop: this cycle pops without granting, next cycle grants
        bus.recv_full = 1'b0;
        #1;
        chk("fp_nogrant", 64'(bus.grant), 64'h0);
        tick();
        chk("fp_ocup3", 64'(bus.ocup), 64'h3);
        chk("fp_head", bus.link_data, 64'h202);
        chk("fp_grant", 64'(bus.grant), 64'h1);
        chk("fp_dir", 64'(bus.grant_dir), 64'h0);
        tick();
        bus.req_valid = '0;
        #1;
        chk("fp_ocup_keep", 64'(bus.ocup), 64'h3);
        chk("fp_head2", bus.link_data, 64'h203);
        tick();
        chk("fp_ocup2", 64'(bus.ocup), 64'h2);
        chk("fp_head3", bus.link_data, 64'h204);
        tick();
        chk("fp_ocup1", 64'(bus.ocup), 64'h1);
        chk("fp_head4", bus.link_data, 64'h200);
        tick();
        chk("fp_empty", 64'(bus.link_valid), 64'h0);

        // Wrap-around: ten flits through port E under random recv_full
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 10 && cyc < 300) begin
            bus.req_valid = (sent < 10) ? 5'b00100 : 5'b00000;
            set_data(2, 64'hA0 + 64'(sent));
            bus.recv_full = 1'($urandom_range(0, 1));
            #1;
            if (bus.link_valid && !bus.recv_full) begin
                if (exp_q.size() == 0) chk("wrap_spurious", 64'(bus.link_valid), 64'h0);
                else chk("wrap_data", bus.link_data, exp_q.pop_front());
                rcvd++;
            end
            if (bus.grant[2]) begin
                exp_q.push_back(64'hA0 + 64'(sent));
                sent++;
            end
            tick();
            cyc++;
        end
        chk("wrap_rcvd", 64'(rcvd), 64'd10);
        chk("wrap_sent", 64'(sent), 64'd10);
        bus.req_valid = '0;
        bus.recv_full = 1'b0;
        #1;
        chk("wrap_empty", 64'(bus.ocup), 64'h0);

        // Mid-operation reset with three flits held under recv_full
        bus.recv_full = 1'b1;
        set_data(3, 64'h300);
        bus.req_valid = 5'b01000;
        for (int k = 0; k < 3; k++) tick();
        bus.req_valid = '0;
        #1;
        chk("mr_ocup3", 64'(bus.ocup), 64'h3);
        reset = 1'b1;
        bus.req_valid = 5'b11111;
        #1;
        chk("mr_grant_in_reset", 64'(bus.grant), 64'h0);
        tick();
        reset = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("mr_link_valid", 64'(bus.link_valid), 64'h0);
        chk("mr_ocup", 64'(bus.ocup), 64'h0);
        chk("mr_dir", 64'(bus.grant_dir), 64'h7);
        chk("mr_link_data", bus.link_data, 64'h0);
        bus.req_valid = 5'b11111;
        #1;
        chk("mr_restart_grant", 64'(bus.grant), 64'h1);
        chk("mr_restart_dir", 64'(bus.grant_dir), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_module.md
# output_module

Output stage for one router direction. It collects 64-bit single-flit packets that the five input modules route toward this direction and arbitrates among them round-robin. Accepted flits are buffered in a small FIFO and driven onto the outgoing link under the neighbour's `recv_full` back-pressure. One instance sits downstream of the five `input_module` instances for each of the N, S, E, W and L outputs.

## Interface
- `DATA_W`, 64, flit width.
- `DEPTH`, 4, output FIFO entries; must be a power of two, at least 2.
- `NUM_IN`, 5, requesting input ports, ordered [L,W,E,S,N] as bits [4:0].
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  5  per-input flit available; bit i = input port i.
- `req_data`  in  5*DATA_W  flattened flits; input i occupies [i*64+63 : i*64].
- `grant`  out  5  one-hot or zero, combinational; flit i is consumed at this edge, and the requester asserts its `read_en` from this bit.
- `grant_dir`  out  3  encoded winner: N=000, S=001, E=010, W=011, L=100; 111 when no grant.
- `link_valid`  out  1  head flit present on `link_data`.
- `link_data`  out  DATA_W  FIFO head.
- `recv_full`  in  1  downstream buffer full; no transfer while high.
- `fifo_full`  out  1  count == DEPTH.
- `ocup`  out  $clog2(DEPTH)+1  current FIFO count.

## Operation
- **Arbiter**
  - Holds a priority pointer `ptr` in 0..4; reset value is 0 (N).
  - The winner is the first `req_valid` bit found scanning `ptr`, `ptr`+1, … modulo 5.
  - `grant` is asserted only if `count < DEPTH`.
  - After a grant to port i, `ptr` ← (i+1) mod 5. Without a grant, `ptr` holds.
- **Push**
  - Occurs when any `grant` bit is set.
  - Writes `req_data` slice i to `mem[wr_ptr]`, then increments `wr_ptr` modulo DEPTH.
- **Pop**
  - Occurs when `link_valid && !recv_full`; `rd_ptr` then increments modulo DEPTH.
  - A transfer on the link is exactly a pop cycle.
- **Count**
  - +1 on push only, −1 on pop only.
  - Unchanged on a simultaneous push and pop.
- **Outputs**
  - `link_valid` = (count != 0).
  - `link_data` = `mem[rd_ptr]`.
  - `fifo_full` = (count == DEPTH).
  - `ocup` = count.
- **Full FIFO**
  - No grant when full, even if a pop occurs in the same cycle. There is no bypass, which keeps `recv_full` off the grant path.
  - Requests stay pending at their input modules; nothing is dropped.
- **Empty FIFO**
  - `link_valid`=0; `recv_full` is ignored.
  - No same-cycle pass-through: a flit granted in cycle t is first visible on the link in cycle t+1.
- **`recv_full` high**
  - Head and `link_valid` hold unchanged.
  - Pushes continue until the FIFO is full.
- **Pointer wrap-around**
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap naturally.
  - Full and empty are distinguished by `count`, not by the pointers.

## Timing
- Arbitration and grant are combinational within cycle t. The flit is captured at the edge ending cycle t.
- Minimum latency from `req_valid` to `link_valid`: 1 cycle.
- Sustained throughput is 1 flit/cycle when `recv_full`=0 and requests are continuous; simultaneous push/pop keeps count constant.
- Reset (synchronous, any cycle, including mid-transfer):
  - `ptr`, `wr_ptr`, `rd_ptr` and `count` ← 0; all `mem` ← 0.
  - Resulting outputs: `grant`=0, `grant_dir`=111, `link_valid`=0, `link_data`=0, `fifo_full`=0, `ocup`=0.
  - During the reset cycle, `grant` is forced to 0 and no push or pop occurs. In-flight FIFO contents are discarded.

## Structure
- Shared package `noc_pkg` holds:
  - Direction codes: N=000, S=001, E=010, W=011, L=100, INVALID=111.
  - `FLIT_W`=64 and `NUM_PORTS`=5.
  - The [L,W,E,S,N] bit-order constants.
  - `input_module` uses the same package.
- One sub-module, `link_fifo` (parameterised DATA_W/DEPTH, with push, pop, count, head). The arbiter stays inline in `output_module`.

## Test plan
- **Reset defaults:** after reset, drive `req_valid`=00001 with N data 0x1 → `grant`=00001, `grant_dir`=000; next cycle `link_valid`=1, `link_data`=0x1, `ocup`=1.
- **Fairness:** all five requests held high, `recv_full`=0 → grant order N,S,E,W,L,N on consecutive cycles; `ocup` stays 1 after the first cycle, and link order matches grant order.
- **Back-pressure:** `recv_full`=1 while 5 single requests arrive → 4 grants, `fifo_full`=1, fifth request waits with `grant`=0. Release `recv_full` → flits exit in FIFO order, one per cycle, and the fifth is granted the cycle after count drops below 4.
- **Full with pop:** FIFO full, `recv_full`=0, request pending → that cycle pops with no grant (`ocup` 4→3); the next cycle grants (`ocup` stays 3).
- **Wrap-around:** push and pop 10 flits with distinct values 0xA0..0xA9 under random `recv_full` → output sequence identical, no loss or duplication.
- **Mid-operation reset:** reset with `ocup`=3 and `recv_full`=1 → next cycle `link_valid`=0, `ocup`=0, `grant_dir`=111; the arbiter restarts at N.
